// File: rtl/mat_mult_pkg.sv
// rtl/mat_mult_pkg.sv - shared types, constants and helpers for the mat_mult job controller
package mat_mult_pkg;

  localparam int N        = 6;
  localparam int W        = 27;
  localparam int PIPE_LAT = 6;

  localparam logic MODE_PAR = 1'b0;
  localparam logic MODE_MAT = 1'b1;

  typedef logic [W-1:0] elem_t;
  typedef elem_t [N-1:0][N-1:0] mat_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Number of enabled beats a job needs in RUN before draining.
  function automatic int unsigned run_len(input logic mode, input int unsigned n);
    return (mode == MODE_MAT) ? n : 32'd1;
  endfunction

endpackage

// File: rtl/mat_mult_ctrl_fsm.sv
// rtl/mat_mult_ctrl_fsm.sv - job sequencer state machine and mat_mult control decode
module mat_mult_ctrl_fsm
  import mat_mult_pkg::*;
#(
  parameter int N        = mat_mult_pkg::N,
  parameter int PIPE_LAT = mat_mult_pkg::PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic job_valid,
  input  logic job_mode,
  input  logic res_ready,
  output logic job_ready,
  output logic res_valid,
  output logic busy,
  output logic mm_rst,
  output logic mm_en,
  output logic mm_mat_mode,
  output logic load,
  output logic snap
);

  localparam int CNT_MAX = (N > PIPE_LAT) ? N : PIPE_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] run_last;
  logic          mode_q, mode_d;
  logic          job_ready_q, job_ready_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;
  logic          clear_q, clear_d;
  logic          en_q, en_d;

  assign run_last = CW'(run_len(mode_q, N) - 32'd1);
  assign load     = (state_q == IDLE) && job_valid;
  assign snap     = (state_q == DRAIN) && (cnt_q == CW'(PIPE_LAT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          state_d = CLEAR;
          mode_d  = job_mode;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (cnt_q == run_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (snap) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet cycle-aligned.
    job_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);
    clear_d     = (state_d == CLEAR);
    en_d        = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_PAR;
      job_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clear_q     <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      job_ready_q <= job_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      clear_q     <= clear_d;
      en_q        <= en_d;
    end
  end

  // The multiplier is also held in reset while the controller itself is.
  assign mm_rst      = rst | clear_q;
  assign mm_en       = en_q;
  assign mm_mat_mode = mode_q;
  assign job_ready   = job_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;

endmodule

// File: rtl/mat_mult_ctrl.sv
// rtl/mat_mult_ctrl.sv - mat_mult job sequencer: operand buffers, result snapshot, optional
// MAT_MULT_CTRL_PERF_EN job/stall counters
module mat_mult_ctrl
  import mat_mult_pkg::*;
#(
  parameter int N        = mat_mult_pkg::N,
  parameter int W        = mat_mult_pkg::W,
  parameter int PIPE_LAT = mat_mult_pkg::PIPE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic               job_mode,
  input  logic [N*N*W-1:0]   job_a,
  input  logic [N*N*W-1:0]   job_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N*N*W-1:0]   res_data,
  output logic               busy,
  output logic               mm_rst,
  output logic               mm_en,
  output logic               mm_mat_mode,
  output logic [N*N*W-1:0]   mm_dataa,
  output logic [N*N*W-1:0]   mm_datab,
  input  logic [N*N*W-1:0]   mm_result
`ifdef MAT_MULT_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_jobs,
  output logic [31:0]        perf_stall
`endif
);

  localparam int MW = N * N * W;

  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic [MW-1:0] res_q, res_d;
  logic          load;
  logic          snap;

  mat_mult_ctrl_fsm #(
    .N        (N),
    .PIPE_LAT (PIPE_LAT)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_mode    (job_mode),
    .res_ready   (res_ready),
    .job_ready   (job_ready),
    .res_valid   (res_valid),
    .busy        (busy),
    .mm_rst      (mm_rst),
    .mm_en       (mm_en),
    .mm_mat_mode (mm_mat_mode),
    .load        (load),
    .snap        (snap)
  );

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (load) begin
      a_d = job_a;
      b_d = job_b;
    end
    if (snap) begin
      res_d = mm_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  assign mm_dataa = a_q;
  assign mm_datab = b_q;
  assign res_data = res_q;

`ifdef MAT_MULT_CTRL_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // res_valid is high exactly while in DONE, so it qualifies both events.
  always_comb begin
    perf_jobs_d  = perf_jobs_q;
    perf_stall_d = perf_stall_q;
    if (res_valid && res_ready && !(&perf_jobs_q)) begin
      perf_jobs_d = perf_jobs_q + 32'd1;
    end
    if (res_valid && !res_ready && !(&perf_stall_q)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_jobs_q  <= perf_jobs_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// tb/tb_mat_mult_ctrl.sv - self-checking bench for mat_mult_ctrl with a behavioural mat_mult stand-in
module tb_mat_mult_ctrl;
  import mat_mult_pkg::*;

  localparam int MD = PIPE_LAT - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic job_mode = 1'b0;
  logic res_ready = 1'b0;
  mat_t job_a = '0;
  mat_t job_b = '0;
  mat_t res_data, mm_dataa, mm_datab, mm_result;
  logic job_ready, res_valid, busy, mm_rst, mm_en, mm_mat_mode;
`ifdef MAT_MULT_CTRL_PERF_EN
  logic [31:0] perf_jobs, perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mat_mult_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_mode    (job_mode),
    .job_a       (job_a),
    .job_b       (job_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .mm_rst      (mm_rst),
    .mm_en       (mm_en),
    .mm_mat_mode (mm_mat_mode),
    .mm_dataa    (mm_dataa),
    .mm_datab    (mm_datab),
    .mm_result   (mm_result)
`ifdef MAT_MULT_CTRL_PERF_EN
    ,
    .perf_jobs   (perf_jobs),
    .perf_stall  (perf_stall)
`endif
  );

  // Multiplier stand-in: beat k adds column/row k products; result settles PIPE_LAT cycles after the beat.
  mat_t mock_acc, mock_nxt, mock_con;
  logic mock_cv;
  int   mock_beat;
  mat_t pipe_c [MD];
  logic pipe_v [MD];
  logic pipe_p [MD];

  assign mm_result = mock_acc;

  always @(posedge clk) begin
    mock_nxt = mock_acc;
    if (pipe_v[MD-1]) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mock_nxt[i][j] = pipe_p[MD-1] ? pipe_c[MD-1][i][j] : elem_t'(mock_acc[i][j] + pipe_c[MD-1][i][j]);
    end
    mock_con = '0;
    mock_cv  = 1'b0;
    if (mm_en && ((mm_mat_mode && mock_beat < N) || (!mm_mat_mode && mock_beat == 0))) begin
      mock_cv = 1'b1;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mock_con[i][j] = mm_mat_mode ? elem_t'(mm_dataa[i][mock_beat] * mm_datab[mock_beat][j])
                                       : elem_t'(mm_dataa[i][j] * mm_datab[i][j]);
    end
    if (mm_rst) begin
      mock_acc  <= '0;
      mock_beat <= 0;
      for (int s = 0; s < MD; s++) pipe_v[s] <= 1'b0;
    end else begin
      mock_acc <= mock_nxt;
      for (int s = MD - 1; s > 0; s--) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_c[s] <= pipe_c[s-1];
        pipe_p[s] <= pipe_p[s-1];
      end
      pipe_v[0] <= mock_cv;
      pipe_c[0] <= mock_con;
      pipe_p[0] <= !mm_mat_mode;
      if (mm_en) mock_beat <= mock_beat + 1;
    end
  end

  function automatic mat_t ref_mult(input logic mode, input mat_t a, input mat_t b);
    mat_t   r;
    longint s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        if (mode)
          for (int k = 0; k < N; k++) s += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
        else
          s = longint'($signed(a[i][j])) * longint'($signed(b[i][j]));
        r[i][j] = elem_t'(s);
      end
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = elem_t'($urandom);
    return r;
  endfunction

  function automatic mat_t fill_mat(input elem_t v);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic mat_t ident_mat();
    mat_t r = '0;
    for (int i = 0; i < N; i++) r[i][i] = elem_t'(1);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; job_valid = 1'b0; res_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Presents a job in an IDLE cycle; returns one cycle later (first cycle after acceptance).
  task automatic offer(input logic mode, input mat_t a, input mat_t b);
    job_mode = mode; job_a = a; job_b = b; job_valid = 1'b1;
    vectors++;
    if (job_ready !== 1'b1) begin miscompares++; $display("FAIL offer_ready: got %b expected 1", job_ready); end
    step();
    job_valid = 1'b0;
    vectors++;
    if ({mm_rst, busy, job_ready} !== 3'b110) begin
      miscompares++; $display("FAIL clear_cycle {mm_rst,busy,job_ready}: got %b expected 110", {mm_rst, busy, job_ready});
    end
  endtask

  task automatic wait_done(input logic mode, output int lat, output int en_cnt, output int en_span, output int mode_err);
    int en_first = -1;
    int en_last  = -1;
    lat = 1; en_cnt = 0; mode_err = 0;
    while (res_valid !== 1'b1 && lat < 64) begin
      if (mm_en === 1'b1) begin
        en_cnt++;
        if (en_first < 0) en_first = lat;
        en_last = lat;
      end
      if (mm_mat_mode !== mode) mode_err++;
      step();
      lat++;
    end
    en_span = (en_first < 0) ? 0 : en_last - en_first + 1;
    vectors++;
    if (res_valid !== 1'b1 || mm_en !== 1'b0) begin
      miscompares++; $display("FAIL done_entry {res_valid,mm_en}: got %b%b expected 10", res_valid, mm_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors++;
    if ({mm_rst, job_ready, res_valid, busy, mm_en, mm_mat_mode} !== 6'b110000) begin
      miscompares++; $display("FAIL reset_outputs: got %b expected 110000", {mm_rst, job_ready, res_valid, busy, mm_en, mm_mat_mode});
    end
    vectors++;
    if (res_data !== '0 || mm_dataa !== '0 || mm_datab !== '0) begin
      miscompares++; $display("FAIL reset_data: res %0h a %0h expected 0", res_data, mm_dataa);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (mm_rst !== 1'b0) begin miscompares++; $display("FAIL mm_rst_release: got %b expected 0", mm_rst); end
  endtask

  task automatic test_matrix_identity();
    mat_t b;
    int lat, en_cnt, en_span, mode_err;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) b[i][j] = elem_t'(i * N + j + 1);
    res_ready = 1'b1;
    offer(MODE_MAT, ident_mat(), b);
    wait_done(MODE_MAT, lat, en_cnt, en_span, mode_err);
    vectors++;
    if (lat != 14) begin miscompares++; $display("FAIL mat_latency: got %0d expected 14", lat); end
    vectors++;
    if (res_data !== b) begin miscompares++; $display("FAIL mat_identity_result: got %0h expected %0h", res_data, b); end
    vectors++;
    if (en_cnt != 12 || en_span != 12) begin
      miscompares++; $display("FAIL mat_en_cycles: got %0d over span %0d expected 12", en_cnt, en_span);
    end
    vectors++;
    if (mode_err != 0) begin miscompares++; $display("FAIL mat_mode_hold: got %0d bad cycles expected 0", mode_err); end
    step();
    vectors++;
    if ({res_valid, job_ready, busy} !== 3'b010) begin
      miscompares++; $display("FAIL mat_return_idle: got %b expected 010", {res_valid, job_ready, busy});
    end
  endtask

  task automatic test_parallel();
    mat_t a, b;
    int lat, en_cnt, en_span, mode_err;
    a = fill_mat(elem_t'(3));
    b = fill_mat(elem_t'(-2));
    res_ready = 1'b1;
    offer(MODE_PAR, a, b);
    wait_done(MODE_PAR, lat, en_cnt, en_span, mode_err);
    vectors++;
    if (lat != 9) begin miscompares++; $display("FAIL par_latency: got %0d expected 9", lat); end
    vectors++;
    if (res_data !== fill_mat(elem_t'(-6))) begin
      miscompares++; $display("FAIL par_result: got %0h expected all -6", res_data);
    end
    vectors++;
    if (en_cnt != 7 || en_span != 7) begin
      miscompares++; $display("FAIL par_en_cycles: got %0d over span %0d expected 7", en_cnt, en_span);
    end
    vectors++;
    if (mode_err != 0 || mm_mat_mode !== 1'b0) begin
      miscompares++; $display("FAIL par_mode: got %0d bad cycles, mode %b expected 0", mode_err, mm_mat_mode);
    end
    step();
  endtask

  task automatic test_backpressure();
    mat_t a, b, snap;
    int lat, en_cnt, en_span, mode_err;
    do_reset();
    a = rand_mat(); b = rand_mat();
    offer(MODE_MAT, a, b);
    wait_done(MODE_MAT, lat, en_cnt, en_span, mode_err);
    snap = ref_mult(MODE_MAT, a, b);
    vectors++;
    if (res_data !== snap) begin miscompares++; $display("FAIL bp_result: got %0h expected %0h", res_data, snap); end
    for (int c = 0; c < 20; c++) begin
      job_valid = c[0] ? 1'b0 : 1'b1;
      job_a = rand_mat(); job_b = rand_mat(); job_mode = 1'($urandom);
      vectors++;
      if ({job_ready, res_valid, busy} !== 3'b011 || res_data !== snap) begin
        miscompares++; $display("FAIL bp_hold c%0d: {ready,valid,busy} %b expected 011, data %0h", c, {job_ready, res_valid, busy}, res_data);
      end
      step();
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    step();
    vectors++;
    if ({res_valid, busy, job_ready} !== 3'b001 || mm_dataa !== a || mm_datab !== b) begin
      miscompares++; $display("FAIL bp_release: {valid,busy,ready} %b expected 001, a %0h", {res_valid, busy, job_ready}, mm_dataa);
    end
`ifdef MAT_MULT_CTRL_PERF_EN
    vectors++;
    if (perf_stall !== 32'd20 || perf_jobs !== 32'd1) begin
      miscompares++; $display("FAIL bp_perf: stall %0d jobs %0d expected 20 1", perf_stall, perf_jobs);
    end
`endif
  endtask

  task automatic test_operand_change();
    mat_t a, b, exp;
    int lat, en_cnt, en_span, mode_err;
    a = rand_mat(); b = rand_mat();
    exp = ref_mult(MODE_MAT, a, b);
    res_ready = 1'b1;
    offer(MODE_MAT, a, b);
    job_a = rand_mat(); job_b = rand_mat();
    wait_done(MODE_MAT, lat, en_cnt, en_span, mode_err);
    vectors++;
    if (res_data !== exp || mm_dataa !== a) begin
      miscompares++; $display("FAIL opchg_result: got %0h expected %0h", res_data, exp);
    end
    step();
  endtask

  task automatic test_reset_mid_job();
    mat_t b;
    int lat, en_cnt, en_span, mode_err;
    res_ready = 1'b1;
    offer(MODE_MAT, rand_mat(), rand_mat());
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({busy, res_valid, mm_en, job_ready} !== 4'b0001 || res_data !== '0) begin
      miscompares++; $display("FAIL midrst_state: {busy,valid,en,ready} %b expected 0001, data %0h", {busy, res_valid, mm_en, job_ready}, res_data);
    end
    step();
    vectors++;
    if (res_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_pulse: got %b expected 0", res_valid); end
    b = rand_mat();
    offer(MODE_MAT, ident_mat(), b);
    wait_done(MODE_MAT, lat, en_cnt, en_span, mode_err);
    vectors++;
    if (res_data !== b || lat != 14) begin
      miscompares++; $display("FAIL midrst_next_job: lat %0d got %0h expected 14 %0h", lat, res_data, b);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mat_t a1, b1, a2, b2;
    int lat, en_cnt, en_span, mode_err;
    do_reset();
    a1 = rand_mat(); b1 = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
    res_ready = 1'b1;
    offer(MODE_MAT, a1, b1);
    wait_done(MODE_MAT, lat, en_cnt, en_span, mode_err);
    job_mode = MODE_PAR; job_a = a2; job_b = b2; job_valid = 1'b1;
    vectors++;
    if (res_data !== ref_mult(MODE_MAT, a1, b1) || job_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_first: ready %b data %0h", job_ready, res_data);
    end
    step();
    vectors++;
    if (job_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_cycle: got %b expected 1", job_ready); end
    step();
    job_valid = 1'b0;
    wait_done(MODE_PAR, lat, en_cnt, en_span, mode_err);
    vectors++;
    if (lat != 9 || res_data !== ref_mult(MODE_PAR, a2, b2)) begin
      miscompares++; $display("FAIL b2b_second: lat %0d got %0h expected 9 %0h", lat, res_data, ref_mult(MODE_PAR, a2, b2));
    end
    step();
`ifdef MAT_MULT_CTRL_PERF_EN
    vectors++;
    if (perf_jobs !== 32'd2) begin miscompares++; $display("FAIL b2b_perf_jobs: got %0d expected 2", perf_jobs); end
`endif
  endtask

  task automatic test_random();
    mat_t a, b, exp;
    logic mode;
    int lat, en_cnt, en_span, mode_err;
    for (int n = 0; n < 8; n++) begin
      mode = 1'($urandom);
      a = rand_mat(); b = rand_mat();
      exp = ref_mult(mode, a, b);
      res_ready = 1'b0;
      offer(mode, a, b);
      wait_done(mode, lat, en_cnt, en_span, mode_err);
      vectors++;
      if (res_data !== exp || lat != (mode ? 2 + N + PIPE_LAT : 3 + PIPE_LAT) || en_cnt != (mode ? N : 1) + PIPE_LAT) begin
        miscompares++; $display("FAIL rand_job%0d mode %b: lat %0d en %0d got %0h expected %0h", n, mode, lat, en_cnt, res_data, exp);
      end
      repeat ($urandom_range(0, 3)) step();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      vectors++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL rand_release%0d: valid %b busy %b expected 0 0", n, res_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_matrix_identity();
    test_parallel();
    test_backpressure();
    test_operand_change();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, miscompares so far %0d", miscompares);
    $fatal(1);
  end

endmodule
